d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop_pkg.sv | 11 +
 rtl/d_flip_flop.sv | 76 +++++++
 tb/tb_d_flip_flop.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/d_flip_flop_pkg.sv
// ----------------------------------------------------------------------------
// d_flip_flop_pkg
//   Shared defaults for the d_flip_flop storage cell.
//   No ports; imported by d_flip_flop.
// ----------------------------------------------------------------------------
package d_flip_flop_pkg;

    // Default register width: a single-bit DFF.
    localparam int DFF_DEFAULT_WIDTH = 1;

endpackage : d_flip_flop_pkg

// File: rtl/d_flip_flop.sv
// ----------------------------------------------------------------------------
// d_flip_flop
//   Positive-edge D flip-flop with synchronous active-high reset and
//   true/complement outputs. Leaf cell: widen WIDTH for multi-bit storage.
//
// Parameters
//   WIDTH        bit width of d, q and qbar
//   RESET_VALUE  value loaded into q on a reset edge; qbar gets its complement
//
// Ports
//   clk    in   1      clock, all state changes on the rising edge
//   reset  in   1      synchronous, active-high reset (priority over d)
//   d      in   WIDTH  data input
//   q      out  WIDTH  registered data, one clock of latency
//   qbar   out  WIDTH  bitwise complement of q
//
// Interface timing: d and reset are sampled only at posedge clk; there is no
// handshake and no enable, every edge either loads d or RESET_VALUE.
// ----------------------------------------------------------------------------
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] q_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= d;
        end
    end

    assign q = q_r;

    // Complement comes from the same register so q and qbar can never disagree.
    assign qbar = ~q_r;

`ifndef SYNTHESIS
    // Becomes 1 after the first reset edge; stays X until then, so the checks
    // below stay quiet while q is still uninitialised.
    logic reset_seen;

    always_ff @(posedge clk) begin
        if (reset === 1'b1) begin
            reset_seen <= 1'b1;
        end
    end

    a_reset_known : assert property (@(posedge clk) !$isunknown(reset))
        else $error("d_flip_flop: reset is X/Z at posedge clk");

    // Preponed q at an edge is what the previous edge loaded.
    a_q_follows : assert property (@(posedge clk)
        (reset_seen === 1'b1) |-> (q === $past(reset ? RESET_VALUE : d)))
        else $error("d_flip_flop: q does not match previous-edge input");

    a_qbar_pos : assert property (@(posedge clk)
        (reset_seen === 1'b1) |-> (qbar === ~q))
        else $error("d_flip_flop: qbar is not ~q at posedge");

    a_qbar_neg : assert property (@(negedge clk)
        (reset_seen === 1'b1) |-> (qbar === ~q))
        else $error("d_flip_flop: qbar is not ~q at negedge");
`endif

endmodule : d_flip_flop

// File: tb/tb_d_flip_flop.sv
// ----------------------------------------------------------------------------
// tb_d_flip_flop
//   Directed bench for d_flip_flop. Two instances share clk and reset: the
//   default 1-bit cell and an 8-bit cell with RESET_VALUE 8'hA5. Inputs are
//   driven on negedge, outputs sampled 1 time unit after posedge (or between
//   edges when checking that nothing moves).
// ----------------------------------------------------------------------------
module tb_d_flip_flop;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic [7:0] d8;
    logic       q1, qbar1;
    logic [7:0] q8, qbar8;

    always #5 clk = ~clk;

    d_flip_flop u_dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d1),
        .q     (q1),
        .qbar  (qbar1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .d     (d8),
        .q     (q8),
        .qbar  (qbar8)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and checking task
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks both instances against the expected q values; qbar expectations
    // are derived here as the plain complement.
    task automatic check_all(input string tag, input logic e1, input logic [7:0] e8);
        logic e1_bar;
        logic [7:0] e8_bar;
        e1_bar = ~e1;
        e8_bar = ~e8;
        check({tag, ".q1"},    {7'b0, q1},    {7'b0, e1});
        check({tag, ".qbar1"}, {7'b0, qbar1}, {7'b0, e1_bar});
        check({tag, ".q8"},    q8,            e8);
        check({tag, ".qbar8"}, qbar8,         e8_bar);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive(input logic rst_v, input logic d1_v, input logic [7:0] d8_v);
        @(negedge clk);
        reset = rst_v;
        d1    = d1_v;
        d8    = d8_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    initial begin
        // 1. Reset held for two edges with d high: reset wins.
        reset = 1'b1;
        d1    = 1'b1;
        d8    = 8'hFF;
        tick();
        tick();
        check_all("reset", 1'b0, 8'hA5);

        // 2. Low then high: q follows one edge after d rises.
        drive(1'b0, 1'b0, 8'h00);
        tick();
        check_all("low", 1'b0, 8'h00);
        drive(1'b0, 1'b1, 8'h3C);
        #2;
        check_all("rise_before_edge", 1'b0, 8'h00);
        tick();
        check_all("rise", 1'b1, 8'h3C);

        // 3. High to low, with no change between edges.
        drive(1'b0, 1'b0, 8'hC3);
        #2;
        check_all("fall_before_edge", 1'b1, 8'h3C);
        tick();
        check_all("fall", 1'b0, 8'hC3);

        // 4. Hold d=1 for three edges.
        drive(1'b0, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("hold", 1'b1, 8'h5A);
        end

        // 5. Mid-stream reset for exactly one edge.
        drive(1'b1, 1'b1, 8'h77);
        tick();
        check_all("mid_reset", 1'b0, 8'hA5);
        drive(1'b0, 1'b1, 8'h81);
        tick();
        check_all("post_reset", 1'b1, 8'h81);

        // 6. Reset pulse entirely between edges: no asynchronous effect.
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all("pulse_during", 1'b1, 8'h81);
        #2;
        reset = 1'b0;
        tick();
        check_all("pulse_after", 1'b1, 8'h81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_d_flip_flop
